// File: rtl/wishbone_xbar.sv
// wishbone_xbar: 2-master x 3-slave Wishbone classic crossbar with per-slave fixed-priority arbitration
module wishbone_xbar #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] ROM_BASE  = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] ROM_MASK  = 32'hC000_0000,
    parameter logic [ADDR_W-1:0] UART_BASE = 32'h4000_0000,
    parameter logic [ADDR_W-1:0] UART_MASK = 32'hC000_0000,
    parameter logic [ADDR_W-1:0] RAM_BASE  = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] RAM_MASK  = 32'hC000_0000,
    localparam int               SEL_W     = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] m0_adr,
    input  logic [DATA_W-1:0] m0_dat_w,
    input  logic [SEL_W-1:0]  m0_sel,
    input  logic              m0_we,
    input  logic              m0_stb,
    input  logic              m0_cyc,
    output logic [DATA_W-1:0] m0_dat_r,
    output logic              m0_ack,
    input  logic [ADDR_W-1:0] m1_adr,
    input  logic [DATA_W-1:0] m1_dat_w,
    input  logic [SEL_W-1:0]  m1_sel,
    input  logic              m1_we,
    input  logic              m1_stb,
    input  logic              m1_cyc,
    output logic [DATA_W-1:0] m1_dat_r,
    output logic              m1_ack,
    output logic [ADDR_W-1:0] rom_adr,
    output logic [DATA_W-1:0] rom_dat_w,
    output logic [SEL_W-1:0]  rom_sel,
    output logic              rom_we,
    output logic              rom_stb,
    output logic              rom_cyc,
    input  logic [DATA_W-1:0] rom_dat_r,
    input  logic              rom_ack,
    output logic [ADDR_W-1:0] ram_adr,
    output logic [DATA_W-1:0] ram_dat_w,
    output logic [SEL_W-1:0]  ram_sel,
    output logic              ram_we,
    output logic              ram_stb,
    output logic              ram_cyc,
    input  logic [DATA_W-1:0] ram_dat_r,
    input  logic              ram_ack,
    output logic [ADDR_W-1:0] uart_adr,
    output logic [DATA_W-1:0] uart_dat_w,
    output logic [SEL_W-1:0]  uart_sel,
    output logic              uart_we,
    output logic              uart_stb,
    output logic              uart_cyc,
    input  logic [DATA_W-1:0] uart_dat_r,
    input  logic              uart_ack
);
    typedef enum logic [1:0] {G_IDLE, G_M0, G_M1} grant_e;

    // Slave index: 0 ROM, 1 RAM, 2 UART, 3 unmapped
    logic [1:0][ADDR_W-1:0] m_adr;
    logic [1:0][DATA_W-1:0] m_dat_w, m_dat_r;
    logic [1:0][SEL_W-1:0]  m_sel;
    logic [1:0]             m_we, m_stb, m_cyc, m_ack, req, err_d, err_q;
    logic [1:0][1:0]        tgt;
    logic [2:0][ADDR_W-1:0] s_adr;
    logic [2:0][DATA_W-1:0] s_dat_w, s_dat_r;
    logic [2:0][SEL_W-1:0]  s_sel;
    logic [2:0]             s_we, s_stb, s_cyc, s_ack, s_en, s_m;
    grant_e                 grant_d [3];
    grant_e                 grant_q [3];

    assign m_adr   = {m1_adr, m0_adr};
    assign m_dat_w = {m1_dat_w, m0_dat_w};
    assign m_sel   = {m1_sel, m0_sel};
    assign m_we    = {m1_we, m0_we};
    assign m_stb   = {m1_stb, m0_stb};
    assign m_cyc   = {m1_cyc, m0_cyc};
    assign {m1_dat_r, m0_dat_r} = m_dat_r;
    assign {m1_ack, m0_ack}     = m_ack;
    assign s_dat_r = {uart_dat_r, ram_dat_r, rom_dat_r};
    assign s_ack   = {uart_ack, ram_ack, rom_ack};
    assign {rom_adr, rom_dat_w, rom_sel, rom_we, rom_stb, rom_cyc} =
           {s_adr[0], s_dat_w[0], s_sel[0], s_we[0], s_stb[0], s_cyc[0]};
    assign {ram_adr, ram_dat_w, ram_sel, ram_we, ram_stb, ram_cyc} =
           {s_adr[1], s_dat_w[1], s_sel[1], s_we[1], s_stb[1], s_cyc[1]};
    assign {uart_adr, uart_dat_w, uart_sel, uart_we, uart_stb, uart_cyc} =
           {s_adr[2], s_dat_w[2], s_sel[2], s_we[2], s_stb[2], s_cyc[2]};

    function automatic logic [1:0] decode(input logic [ADDR_W-1:0] a);
        return ((a & ROM_MASK) == ROM_BASE)   ? 2'd0 :
               ((a & RAM_MASK) == RAM_BASE)   ? 2'd1 :
               ((a & UART_MASK) == UART_BASE) ? 2'd2 : 2'd3;
    endfunction

    // Decode targets; unmapped strobes get a one-cycle ack pulse from the crossbar
    always_comb begin
        for (int m = 0; m < 2; m++) begin
            tgt[m]   = decode(m_adr[m]);
            req[m]   = m_cyc[m] & m_stb[m];
            err_d[m] = req[m] && tgt[m] == 2'd3 && !err_q[m];
        end
    end

    // Idle slaves grant m0 before m1; an owned slave is held until its owner drops cyc
    always_comb begin
        for (int s = 0; s < 3; s++) begin
            grant_d[s] = (grant_q[s] == G_IDLE) ?
                             ((req[0] && tgt[0] == 2'(s)) ? G_M0 :
                              (req[1] && tgt[1] == 2'(s)) ? G_M1 : G_IDLE) :
                         (grant_q[s] == G_M0) ? (m_cyc[0] ? G_M0 : G_IDLE) :
                                                (m_cyc[1] ? G_M1 : G_IDLE);
        end
    end

    // Grant and unmapped-ack registers; reset idles every slave port immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 3; s++) grant_q[s] <= G_IDLE;
            err_q <= '0;
        end else begin
            grant_q <= grant_d;
            err_q   <= err_d;
        end
    end

    // Drive each slave from its owning master, or hold it quiet when idle
    always_comb begin
        for (int s = 0; s < 3; s++) begin
            s_en[s]    = grant_q[s] != G_IDLE;
            s_m[s]     = grant_q[s] == G_M1;
            s_adr[s]   = s_en[s] ? m_adr[s_m[s]]   : '0;
            s_dat_w[s] = s_en[s] ? m_dat_w[s_m[s]] : '0;
            s_sel[s]   = s_en[s] ? m_sel[s_m[s]]   : '0;
            s_we[s]    = s_en[s] & m_we[s_m[s]];
            s_stb[s]   = s_en[s] & m_stb[s_m[s]];
            s_cyc[s]   = s_en[s] & m_cyc[s_m[s]];
        end
    end

    // Return ack/data only from the master's current target, and only if it owns that slave
    always_comb begin
        for (int m = 0; m < 2; m++) begin
            m_ack[m]   = err_q[m];
            m_dat_r[m] = '0;
            for (int s = 0; s < 3; s++) begin
                if (tgt[m] == 2'(s) && grant_q[s] == (m == 0 ? G_M0 : G_M1)) begin
                    m_ack[m]   = s_ack[s];
                    m_dat_r[m] = s_dat_r[s];
                end
            end
        end
    end
endmodule

// File: tb/tb_wishbone_xbar.sv
// tb_wishbone_xbar: directed plus randomized checks of the crossbar against ROM/RAM models and a RAM reference
module tb_wishbone_xbar;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] m_adr [2];
    logic [31:0] m_dat_w [2];
    logic [31:0] m_dat_r [2];
    logic [3:0]  m_sel [2];
    logic        m_we [2];
    logic        m_stb [2];
    logic        m_cyc [2];
    logic        m_ack [2];
    logic [31:0] rom_adr, rom_dat_w, rom_dat_r, ram_adr, ram_dat_w, ram_dat_r, uart_adr, uart_dat_w, uart_dat_r;
    logic [3:0]  rom_sel, ram_sel, uart_sel;
    logic        rom_we, rom_stb, rom_cyc, rom_ack, ram_we, ram_stb, ram_cyc, ram_ack;
    logic        uart_we, uart_stb, uart_cyc, uart_ack;
    logic        rom_ack_q, ram_ack_q;
    logic [31:0] rom_mem [64];
    logic [31:0] ram_mem [64];
    logic [31:0] ram_ref [64];
    int          n_cmp = 0, n_err = 0;
    int          ram_stb_cnt = 0, uart_cnt = 0, rom_wr_cnt = 0;
    int          s_ram, s_uart;
    logic [31:0] r0, r1, w;
    int          l0, l1;
    int          k [2];
    int          idx [2];
    int          cls [2];
    int          el [2];
    int          rl [2];
    logic [31:0] ra [2];
    logic [31:0] rw [2];
    logic [31:0] re [2];
    logic [31:0] rr [2];

    always #10 clk = ~clk;

    wishbone_xbar dut (
        .clk(clk), .rst_n(rst_n),
        .m0_adr(m_adr[0]), .m0_dat_w(m_dat_w[0]), .m0_sel(m_sel[0]), .m0_we(m_we[0]),
        .m0_stb(m_stb[0]), .m0_cyc(m_cyc[0]), .m0_dat_r(m_dat_r[0]), .m0_ack(m_ack[0]),
        .m1_adr(m_adr[1]), .m1_dat_w(m_dat_w[1]), .m1_sel(m_sel[1]), .m1_we(m_we[1]),
        .m1_stb(m_stb[1]), .m1_cyc(m_cyc[1]), .m1_dat_r(m_dat_r[1]), .m1_ack(m_ack[1]),
        .rom_adr(rom_adr), .rom_dat_w(rom_dat_w), .rom_sel(rom_sel), .rom_we(rom_we),
        .rom_stb(rom_stb), .rom_cyc(rom_cyc), .rom_dat_r(rom_dat_r), .rom_ack(rom_ack),
        .ram_adr(ram_adr), .ram_dat_w(ram_dat_w), .ram_sel(ram_sel), .ram_we(ram_we),
        .ram_stb(ram_stb), .ram_cyc(ram_cyc), .ram_dat_r(ram_dat_r), .ram_ack(ram_ack),
        .uart_adr(uart_adr), .uart_dat_w(uart_dat_w), .uart_sel(uart_sel), .uart_we(uart_we),
        .uart_stb(uart_stb), .uart_cyc(uart_cyc), .uart_dat_r(uart_dat_r), .uart_ack(uart_ack)
    );

    // ROM and RAM slaves ack one cycle after strobe; UART is tied off but never left hanging
    assign rom_ack    = rom_ack_q;
    assign rom_dat_r  = rom_mem[rom_adr[7:2]];
    assign ram_ack    = ram_ack_q;
    assign ram_dat_r  = ram_mem[ram_adr[7:2]];
    assign uart_ack   = uart_cyc & uart_stb;
    assign uart_dat_r = 32'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_ack_q <= 1'b0;
            ram_ack_q <= 1'b0;
        end else begin
            rom_ack_q <= rom_cyc & rom_stb & !rom_ack_q;
            ram_ack_q <= ram_cyc & ram_stb & !ram_ack_q;
            if (ram_cyc && ram_stb && ram_we && !ram_ack_q)
                for (int b = 0; b < 4; b++)
                    if (ram_sel[b]) ram_mem[ram_adr[7:2]][8*b +: 8] <= ram_dat_w[8*b +: 8];
        end
    end

    // Activity monitors on slave ports
    always @(posedge clk) begin
        if (ram_stb) ram_stb_cnt++;
        if (uart_cyc || uart_stb || uart_we || (|uart_adr) || (|uart_dat_w) || (|uart_sel)) uart_cnt++;
        if (rom_cyc && rom_stb && rom_we) rom_wr_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // One classic transfer; lat is negedges from strobe to ack, -1 if it never comes
    task automatic xfer(input int m, input logic we, input logic [31:0] adr, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat);
        @(negedge clk);
        m_adr[m] = adr; m_dat_w[m] = wd; m_we[m] = we; m_sel[m] = 4'hF;
        m_cyc[m] = 1'b1; m_stb[m] = 1'b1;
        lat = -1;
        rd = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (m_ack[m]) begin
                lat = i;
                rd = m_dat_r[m];
                break;
            end
        end
        m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            rom_mem[i] = $urandom;
            ram_mem[i] = '0;
            ram_ref[i] = '0;
        end
        for (int m = 0; m < 2; m++) begin
            m_adr[m] = '0; m_dat_w[m] = '0; m_sel[m] = '0; m_we[m] = 1'b0;
        end
        // m0 requests ROM while reset holds; nothing may reach the slave
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        #5;
        chk("rst_m0_ack", 32'(m_ack[0]), 0);
        chk("rst_m0_dat", m_dat_r[0], 0);
        chk("rst_rom_cyc", 32'(rom_cyc), 0);
        #10;
        chk("rst_rom_stb_after_edge", 32'(rom_stb), 0);
        chk("rst_ram_adr", ram_adr, 0);
        chk("rst_m1_ack", 32'(m_ack[1]), 0);
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        #5 rst_n = 1'b1;

        // 1: ROM read, no stray traffic on RAM/UART
        s_ram = ram_stb_cnt; s_uart = uart_cnt;
        xfer(0, 1'b0, 32'h0000_0000, 0, r0, l0);
        chk("t1_lat", l0, 2);
        chk("t1_dat", r0, rom_mem[0]);
        chk("t1_ram_quiet", ram_stb_cnt - s_ram, 0);
        chk("t1_uart_quiet", uart_cnt - s_uart, 0);

        // 2: RAM write and readback
        xfer(0, 1'b1, 32'h8000_0000, 32'hDEAD_BEEF, r0, l0);
        ram_ref[0] = 32'hDEAD_BEEF;
        chk("t2_wr_lat", l0, 2);
        xfer(0, 1'b0, 32'h8000_0000, 0, r0, l0);
        chk("t2_rd", r0, 32'hDEAD_BEEF);

        // 3: m1 writes an unaligned RAM address while m0 holds RAM
        fork
            xfer(0, 1'b0, 32'h8000_0000, 0, r0, l0);
            begin #30 xfer(1, 1'b1, 32'h8000_0012, 32'hCAFE_BABE, r1, l1); end
        join
        ram_ref[4] = 32'hCAFE_BABE;
        chk("t3_m0_rd", r0, 32'hDEAD_BEEF);
        chk("t3_m1_acked", 32'(l1 > 0), 1);
        xfer(1, 1'b0, 32'h8000_0010, 0, r1, l1);
        chk("t3_m1_rd", r1, 32'hCAFE_BABE);
        xfer(0, 1'b0, 32'h8000_0000, 0, r0, l0);
        chk("t3_m0_rd_again", r0, 32'hDEAD_BEEF);

        // 4: same-cycle contention for RAM; m0 first, m1 stalls then sees m0's data
        w = $urandom;
        fork
            xfer(0, 1'b1, 32'h8000_0020, w, r0, l0);
            xfer(1, 1'b0, 32'h8000_0020, 0, r1, l1);
        join
        ram_ref[8] = w;
        chk("t4_m0_lat", l0, 2);
        chk("t4_m1_lat", l1, 5);
        chk("t4_m1_dat", r1, w);

        // 5: disjoint slaves are served concurrently
        fork
            xfer(0, 1'b0, 32'h0000_000C, 0, r0, l0);
            xfer(1, 1'b0, 32'h8000_0000, 0, r1, l1);
        join
        chk("t5_m0_lat", l0, 2);
        chk("t5_m1_lat", l1, 2);
        chk("t5_m0_dat", r0, rom_mem[3]);
        chk("t5_m1_dat", r1, 32'hDEAD_BEEF);
        xfer(1, 1'b0, 32'h0000_0004, 0, r1, l1);
        chk("t5_m1_rom1", r1, rom_mem[1]);

        // 6: unmapped access acks locally with zero data
        xfer(0, 1'b0, 32'hF000_0000, 0, r0, l0);
        chk("t6_unmapped_lat", l0, 1);
        chk("t6_unmapped_dat", r0, 0);
        xfer(1, 1'b1, 32'hC000_0040, 32'h1234_5678, r1, l1);
        chk("t6_unmapped_wr_lat", l1, 1);

        // Randomized concurrent traffic against the RAM reference
        for (int it = 0; it < 16; it++) begin
            for (int m = 0; m < 2; m++) begin
                k[m] = $urandom_range(0, 3);
                idx[m] = $urandom_range(0, 63);
                rw[m] = $urandom;
                cls[m] = k[m] == 0 ? 0 : k[m] == 3 ? 2 : 1;
                ra[m] = k[m] == 0 ? 32'(idx[m]) << 2 :
                        k[m] == 3 ? (32'hC000_0000 | ($urandom & 32'h3FFF_FFFC)) :
                        (32'h8000_0000 | (32'(idx[m]) << 2) | 32'($urandom_range(0, 3)));
            end
            for (int m = 0; m < 2; m++) begin
                re[m] = k[m] == 0 ? rom_mem[idx[m]] : k[m] == 1 ? ram_ref[idx[m]] :
                        k[m] == 2 ? rw[m] : 32'h0;
                if (k[m] == 2) ram_ref[idx[m]] = rw[m];
            end
            el[0] = cls[0] == 2 ? 1 : 2;
            el[1] = (cls[1] == cls[0] && cls[1] != 2) ? 5 : cls[1] == 2 ? 1 : 2;
            fork
                xfer(0, k[0] == 2, ra[0], rw[0], rr[0], rl[0]);
                xfer(1, k[1] == 2, ra[1], rw[1], rr[1], rl[1]);
            join
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("rnd%0d_m%0d_lat", it, m), rl[m], el[m]);
                chk($sformatf("rnd%0d_m%0d_dat", it, m), rr[m], re[m]);
            end
        end
        for (int i = 0; i < 64; i++) chk($sformatf("ram_word%0d", i), ram_mem[i], ram_ref[i]);
        chk("rom_never_written", rom_wr_cnt, 0);

        // Reset mid-transfer drops slave strobes without waiting for a clock edge
        @(negedge clk);
        m_adr[0] = 32'h0000_0010; m_we[0] = 1'b0; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        @(posedge clk);
        #2;
        chk("t6_rom_granted", 32'(rom_cyc), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_rom_cyc", 32'(rom_cyc), 0);
        chk("t6_rst_rom_stb", 32'(rom_stb), 0);
        chk("t6_rst_m0_ack", 32'(m_ack[0]), 0);
        @(negedge clk);
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        xfer(0, 1'b0, 32'h0000_0008, 0, r0, l0);
        chk("t6_post_rst_lat", l0, 2);
        chk("t6_post_rst_dat", r0, rom_mem[2]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
